// File: rtl/cnt_pwm_pkg.sv
// Shared types and constants for the counter-driven PWM generator.
// Optional polarity inversion is controlled by the CNT_PWM_INVERT_EN macro.
package cnt_pwm_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int PCNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_e;

  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/cnt_prd_det.sv
// Period-start detector: flags the cycle where the upstream counter arrives at zero
// from a non-zero value, so a counter parked at zero yields only one start.
module cnt_prd_det
  import cnt_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_ps
);

  logic [CNT_W-1:0] r_cnt_prev;
  logic             r_prev_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_prev <= '0;
      r_prev_vld <= 1'b0;
    end else begin
      r_cnt_prev <= i_cnt;
      r_prev_vld <= 1'b1;
    end
  end

  assign o_ps = r_prev_vld & (i_cnt == '0) & (r_cnt_prev != '0);

endmodule

// File: rtl/cnt_pwm_gen.sv
// PWM generator slaved to the free-running upstream counter, with double-buffered duty.
// Define CNT_PWM_INVERT_EN to add the i_pol input that XORs the registered output.
module cnt_pwm_gen
  import cnt_pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PCNT_W = PCNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CNT_W-1:0]  i_cnt_in,
  input  logic              i_en,
  input  logic [CNT_W-1:0]  i_duty_in,
  input  logic              i_duty_vld,
`ifdef CNT_PWM_INVERT_EN
  input  logic              i_pol,
`endif
  output logic              o_duty_rdy,
  output logic              o_pwm_out,
  output logic              o_prd_start,
  output logic [PCNT_W-1:0] o_prd_cnt,
  output logic              o_busy
);

  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(cnt_max(PCNT_W));

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_pwm;
  logic               w_pwm_nxt;
  logic               r_prd_start;
  logic [PCNT_W-1:0]  r_prd_cnt;
  logic [CNT_W-1:0]   r_shadow;
  logic [CNT_W-1:0]   r_active;
  logic               r_pending;
  logic               w_ps;
  logic               w_accept;
  logic               w_take;
  logic [CNT_W-1:0]   w_duty_eff;
  logic               w_cmp;
  logic               w_pol;

`ifdef CNT_PWM_INVERT_EN
  assign w_pol = i_pol;
`else
  assign w_pol = 1'b0;
`endif

  cnt_prd_det #(
    .CNT_W (CNT_W)
  ) u_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_cnt   (i_cnt_in),
    .o_ps    (w_ps)
  );

  // The shadow is only writable while empty, so an accept never coincides with a take.
  assign w_accept   = i_duty_vld & ~r_pending;
  assign w_take     = w_ps & r_pending;
  assign w_duty_eff = w_take ? r_shadow : r_active;
  assign w_cmp      = (i_cnt_in < w_duty_eff);

  always_comb begin
    w_state_nxt = r_state;
    w_pwm_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en) w_state_nxt = ARM;
      end
      ARM: begin
        if (!i_en) begin
          w_state_nxt = IDLE;
        end else if (w_ps) begin
          w_state_nxt = RUN;
          w_pwm_nxt   = w_cmp;
        end
      end
      RUN: begin
        if (w_ps && !i_en) begin
          w_state_nxt = IDLE;
        end else begin
          w_pwm_nxt = w_cmp;
          if (!i_en) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (i_en) begin
          w_state_nxt = RUN;
          w_pwm_nxt   = w_cmp;
        end else if (w_ps) begin
          w_state_nxt = IDLE;
        end else begin
          w_pwm_nxt = w_cmp;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_pwm       <= 1'b0;
      r_prd_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pwm       <= w_pwm_nxt ^ w_pol;
      r_prd_start <= w_ps;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prd_cnt <= '0;
    end else if (w_ps && (r_state == RUN || r_state == STOP) && (r_prd_cnt != PCNT_MAX)) begin
      r_prd_cnt <= r_prd_cnt + PCNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_take) r_active <= r_shadow;
      if (w_accept) begin
        r_shadow  <= i_duty_in;
        r_pending <= 1'b1;
      end else if (w_take) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_duty_rdy  = ~r_pending;
  assign o_pwm_out   = r_pwm;
  assign o_prd_start = r_prd_start;
  assign o_prd_cnt   = r_prd_cnt;
  assign o_busy      = (r_state != IDLE);

endmodule
